// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory loader: packs little-endian bytes into 32-bit words and writes them out.
// Define IMEM_LOADER_CHECKSUM_EN to add a running XOR checksum output of every written word.
module imem_loader #(
  parameter int MEM_DEPTH = 1024,
  parameter int AW        = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   num_words,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          done,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic [31:0]   checksum,
`endif
  output logic [AW:0]   words_written
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(MEM_DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  state_t      state, state_nxt;
  logic [AW:0] target;
  logic [AW:0] clamped;
  logic [1:0]  byte_cnt;
  logic [23:0] byte_buf;
  logic        accept;
  logic        byte_xfer;
  logic        last_write;

  assign accept     = start && (state != LOAD);
  assign in_ready   = (state == LOAD) && !mem_we;
  assign byte_xfer  = in_valid && in_ready;
  assign clamped    = (num_words > DEPTH_W) ? DEPTH_W : num_words;
  assign last_write = mem_we && ((words_written + ONE_W) == target);
  assign busy       = (state == LOAD);
  assign done       = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (accept) state_nxt = (clamped == '0) ? DONE : LOAD;
      LOAD:       if (last_write) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // A completed word is held for one write cycle; the stream is stalled while it drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      target        <= '0;
      words_written <= '0;
      byte_cnt      <= '0;
      byte_buf      <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else if (accept) begin
      target        <= clamped;
      words_written <= '0;
      byte_cnt      <= '0;
      mem_we        <= 1'b0;
    end else if (state == LOAD) begin
      if (mem_we) begin
        mem_we        <= 1'b0;
        words_written <= words_written + ONE_W;
      end else if (byte_xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0: byte_buf[7:0]   <= in_data;
          2'd1: byte_buf[15:8]  <= in_data;
          2'd2: byte_buf[23:16] <= in_data;
          default: begin
            mem_we    <= 1'b1;
            mem_wdata <= {in_data, byte_buf};
            mem_addr  <= {{(30-AW){1'b0}}, words_written[AW-1:0], 2'b00};
          end
        endcase
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || accept)
      checksum <= '0;
    else if ((state == LOAD) && mem_we)
      checksum <= checksum ^ mem_wdata;
  end
`endif

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024: number of 32-bit words in the target instruction memory (power of two, >= 4).
REQ-002 SHALL have parameter AW, default $clog2(MEM_DEPTH): word-index width.
REQ-003 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-006 SHALL have port num_words  input  AW+1  number of words to load, sampled on an accepted start.
REQ-007 SHALL have port in_valid  input  1  byte-stream valid.
REQ-008 SHALL have port in_data  input  8  byte-stream data.
REQ-009 SHALL have port in_ready  output  1  byte-stream ready.
REQ-010 SHALL have port mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 SHALL have port mem_addr  output  32  byte address of the word being written.
REQ-012 SHALL have port mem_wdata  output  32  word being written.
REQ-013 SHALL have port busy  output  1  high while in LOAD.
REQ-014 SHALL have port done  output  1  high while in DONE.
REQ-015 SHALL have port words_written  output  AW+1  count of words written in the current load.

Function
REQ-016 SHALL implement the states IDLE, LOAD and DONE.
REQ-017 SHALL accept start only in IDLE or DONE and SHALL ignore start in LOAD.
REQ-018 On an accepted start, SHALL latch min(num_words, MEM_DEPTH), clear words_written and the byte counter, then go to LOAD, or go straight to DONE if the latched value is 0.
REQ-019 SHALL drive in_ready to 1 only in LOAD when no write is pending; a byte transfers when in_valid && in_ready.
REQ-020 SHALL assemble words little-endian: the first accepted byte goes to bits [7:0] and the fourth to bits [31:24].
REQ-021 SHALL drive mem_we high for exactly one cycle, in the cycle after the fourth byte of a word is accepted, with in_ready low in that cycle.
REQ-022 SHALL hold mem_addr and mem_wdata valid while mem_we is high.
REQ-023 SHALL set mem_addr to {zeros, word_index[AW-1:0], 2'b00}, with bits [1:0] and bits above AW+1 equal to 0.
REQ-024 SHALL increment words_written in the same edge that deasserts mem_we.
REQ-025 SHALL go to DONE in the cycle after the write that makes words_written equal the latched count.
REQ-026 SHALL keep done high in DONE until the next accepted start, and SHALL keep busy low in IDLE and DONE.
REQ-027 SHALL let in_valid gaps of any length stall assembly without losing or duplicating bytes.
REQ-028 SHALL never issue mem_we outside LOAD, never more writes than the latched count, and never write a partial word.

Reset
REQ-029 On reset, SHALL enter IDLE and zero every output (in_ready, mem_we, mem_addr, mem_wdata, busy, done, words_written, and checksum when present).
REQ-030 Reset SHALL take priority over start and over in_valid in the same cycle.
REQ-031 Reset during LOAD SHALL discard the partial word and any pending write, and no mem_we SHALL follow the reset.

Configuration
REQ-032 With macro IMEM_LOADER_CHECKSUM_EN defined, the block SHALL add output port checksum (32 bits), the running XOR of every written mem_wdata, cleared on reset and on an accepted start and updated in the same edge as words_written.
REQ-033 Without IMEM_LOADER_CHECKSUM_EN, the checksum port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 SHALL cover: reset, start with num_words=2, bytes 13 00 00 00 93 00 10 00 -> mem_we at addr 0x0 with data 0x00000013, then at addr 0x4 with data 0x00100093; done=1; words_written=2.
REQ-035 SHALL cover: the same stream with 3-cycle in_valid gaps between bytes -> the same two writes, exactly two mem_we pulses.
REQ-036 SHALL cover: start with num_words=0 -> done=1 the next cycle, no mem_we, in_ready stays 0.
REQ-037 SHALL cover: reset asserted after 6 bytes of a 2-word load -> exactly one write (0x00000013 at 0x0), then IDLE with all outputs 0.
REQ-038 SHALL cover: MEM_DEPTH=1024, num_words=2000 -> 1024 writes, last at addr 0xFFC, done=1, words_written=1024.
REQ-039 SHALL cover: with IMEM_LOADER_CHECKSUM_EN defined, the REQ-034 stream -> checksum=0x00100080; a new start -> checksum=0.
